// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
//   Registered immediate-decode stage between fetch and execute. Decodes the
//   immediate, format code and illegal flag of a raw RISC-V instruction and
//   presents them one cycle later together with the PC and pc+imm target.
//   A two-entry buffer (output register O + skid register S) keeps one
//   instruction per cycle flowing under back-pressure, with in_ready driven
//   purely from registers.
//
// Parameters
//   XLEN       datapath width, 32 or 64
//   PC_ADJUST  constant subtracted from B/J immediates (fetch-ahead offset)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of O and S (drops same-cycle input)
//   in_valid/in_ready   input handshake; in_ready is registered
//   in_instr, in_pc     instruction word and its address
//   out_valid/out_ready output handshake
//   out_imm, out_fmt    decoded immediate and format code
//   out_illegal         unsupported encoding (entry still passed through)
//   out_pc, out_target  PC of presented entry and out_pc + out_imm
// -----------------------------------------------------------------------------
module imm_decode_stage #(
    parameter int XLEN      = 32,
    parameter int PC_ADJUST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_CSR   = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
        logic [XLEN-1:0] pc;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode. Every candidate immediate is formed at 64 bits and truncated
    // to XLEN at the end, so sign extension and the PC_ADJUST subtraction
    // behave identically for both widths (arithmetic is mod 2^XLEN).
    // ------------------------------------------------------------------
    logic [31:0] ins;
    logic [2:0]  funct3;
    logic        is_shift;
    logic        shamt_ok;
    logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_csr, imm_sh;

    assign ins      = in_instr;
    assign funct3   = ins[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    // RV32 only has 5-bit shift amounts; bit 25 set is not a valid encoding.
    assign shamt_ok = RV64 || !ins[25];

    assign imm_i   = {{52{ins[31]}}, ins[31:20]};
    assign imm_s   = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b   = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}
                     - 64'(PC_ADJUST);
    assign imm_j   = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}
                     - 64'(PC_ADJUST);
    assign imm_u   = {{32{ins[31]}}, ins[31:12], 12'h000};
    assign imm_csr = {52'd0, ins[31:20]};
    assign imm_sh  = RV64 ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};

    logic [63:0] dec_imm64;
    logic [2:0]  dec_fmt;
    logic        dec_ill;
    entry_t      dec_e;

    always_comb begin
        dec_imm64 = '0;
        dec_fmt   = FMT_NONE;
        dec_ill   = 1'b0;
        case (ins[6:0])
            7'b0000011, 7'b0001111, 7'b1100111: begin   // LOAD, MISC-MEM, JALR
                dec_fmt   = FMT_I;
                dec_imm64 = imm_i;
            end
            7'b0010011, 7'b0011011: begin               // OP-IMM, OP-IMM-32
                if (ins[6:0] == 7'b0011011 && !RV64) begin
                    dec_ill = 1'b1;
                end else if (is_shift) begin
                    if (shamt_ok) begin
                        dec_fmt   = FMT_SHAMT;
                        dec_imm64 = imm_sh;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm64 = imm_i;
                end
            end
            7'b0100011: begin                           // STORE
                dec_fmt   = FMT_S;
                dec_imm64 = imm_s;
            end
            7'b1100011: begin                           // BRANCH
                dec_fmt   = FMT_B;
                dec_imm64 = imm_b;
            end
            7'b1101111: begin                           // JAL
                dec_fmt   = FMT_J;
                dec_imm64 = imm_j;
            end
            7'b0110111, 7'b0010111: begin               // LUI, AUIPC
                dec_fmt   = FMT_U;
                dec_imm64 = imm_u;
            end
            7'b1110011: begin                           // SYSTEM
                dec_fmt   = FMT_CSR;
                dec_imm64 = imm_csr;
            end
            7'b0110011: ;                               // OP: legal, no immediate
            7'b0111011: dec_ill = !RV64;                // OP-32
            default:    dec_ill = 1'b1;                 // includes instr[1:0] != 2'b11
        endcase
    end

    assign dec_e.imm = XLEN'(dec_imm64);
    assign dec_e.fmt = dec_fmt;
    assign dec_e.ill = dec_ill;
    assign dec_e.pc  = in_pc;

    // ------------------------------------------------------------------
    // Output register O + skid register S.
    // S is only ever occupied while O is, and in_ready is simply "S empty",
    // so an accepted input never collides with an S->O move.
    // ------------------------------------------------------------------
    entry_t o_q, o_d, s_q, s_d;
    logic   o_vld_q, o_vld_d, s_vld_q, s_vld_d;
    logic   in_fire, out_fire;

    assign in_ready = !s_vld_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = o_vld_q && out_ready;

    always_comb begin
        o_d     = o_q;
        s_d     = s_q;
        o_vld_d = o_vld_q;
        s_vld_d = s_vld_q;
        if (flush) begin
            o_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else begin
            if (out_fire) begin
                if (s_vld_q) begin
                    o_d     = s_q;
                    s_vld_d = 1'b0;
                end else begin
                    o_vld_d = 1'b0;
                end
            end
            // o_vld_d already reflects this cycle's output transfer.
            if (in_fire) begin
                if (!o_vld_d) begin
                    o_d     = dec_e;
                    o_vld_d = 1'b1;
                end else begin
                    s_d     = dec_e;
                    s_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q     <= '0;
            s_q     <= '0;
            o_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
        end else begin
            o_q     <= o_d;
            s_q     <= s_d;
            o_vld_q <= o_vld_d;
            s_vld_q <= s_vld_d;
        end
    end

    assign out_valid   = o_vld_q;
    assign out_imm     = o_q.imm;
    assign out_fmt     = o_q.fmt;
    assign out_illegal = o_q.ill;
    assign out_pc      = o_q.pc;
    assign out_target  = o_q.pc + o_q.imm;

endmodule

// File: tb/tb_imm_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_stage
//   Drives an XLEN=32 and an XLEN=64 instance with identical handshakes and
//   instruction words. Expected entries come from an arithmetic reference
//   decoder and flow through per-instance queues; occupancy of each queue
//   gives the expected in_ready / out_valid.
// -----------------------------------------------------------------------------
module tb_imm_decode_stage;

    localparam int PA = 4;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        r32, v32, ill32;
    logic [31:0] imm32, opc32, tgt32;
    logic [2:0]  fmt32;
    logic        r64, v64, ill64;
    logic [63:0] imm64, opc64, tgt64;
    logic [2:0]  fmt64;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .PC_ADJUST(PA)) d32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_pc(pc32),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_pc(opc32), .out_target(tgt32)
    );

    imm_decode_stage #(.XLEN(64), .PC_ADJUST(PA)) d64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_pc(pc64),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_pc(opc64), .out_target(tgt64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] pc;
        logic [63:0] tgt;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t q[2][$];
    bit   hold[2];
    exp_t hsnap[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sx(input longint raw, input int w);
        return raw[w-1] ? raw - (longint'(1) << w) : raw;
    endfunction

    function automatic logic [63:0] msk(input logic [63:0] v, input int xl);
        return (xl == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input int xl);
        exp_t        e;
        longint      v  = 0;
        logic [2:0]  f  = 3'd0;
        bit          il = 1'b0;
        logic [2:0]  f3 = ins[14:12];
        bit          sh = (f3 == 3'd1) || (f3 == 3'd5);
        case (ins[6:0])
            7'b0000011, 7'b0001111, 7'b1100111: begin f = 3'd1; v = sx(longint'(ins[31:20]), 12); end
            7'b0010011, 7'b0011011: begin
                if (ins[6:0] == 7'b0011011 && xl == 32) il = 1'b1;
                else if (sh) begin
                    if (xl == 32 && ins[25]) il = 1'b1;
                    else begin
                        f = 3'd6;
                        v = (xl == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
                    end
                end else begin f = 3'd1; v = sx(longint'(ins[31:20]), 12); end
            end
            7'b0100011: begin f = 3'd2; v = sx(longint'({ins[31:25], ins[11:7]}), 12); end
            7'b1100011: begin
                f = 3'd3;
                v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13) - PA;
            end
            7'b1101111: begin
                f = 3'd5;
                v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21) - PA;
            end
            7'b0110111, 7'b0010111: begin f = 3'd4; v = sx(longint'(ins[31:12]), 20) * 4096; end
            7'b1110011: begin f = 3'd7; v = longint'(ins[31:20]); end
            7'b0110011: ;
            7'b0111011: il = (xl == 32);
            default:    il = 1'b1;
        endcase
        e.imm = msk(64'(v), xl);
        e.fmt = f;
        e.ill = il;
        e.pc  = msk(pc, xl);
        e.tgt = msk(e.pc + e.imm, xl);
        return e;
    endfunction

    // ---------------- per-cycle checking ----------------
    task automatic cmp_entry(input string tag, input exp_t o, input exp_t e);
        chk({tag, ".imm"}, o.imm, e.imm);
        chk({tag, ".fmt"}, 64'(o.fmt), 64'(e.fmt));
        chk({tag, ".ill"}, 64'(o.ill), 64'(e.ill));
        chk({tag, ".pc"},  o.pc, e.pc);
        chk({tag, ".tgt"}, o.tgt, e.tgt);
    endtask

    task automatic side(input int k, input exp_t ob, input logic rdy, input logic vld);
        string nm = (k == 0) ? "x32" : "x64";
        int    xl = (k == 0) ? 32 : 64;
        chk({nm, ".in_ready"},  64'(rdy), 64'(q[k].size() < 2));
        chk({nm, ".out_valid"}, 64'(vld), 64'(q[k].size() > 0));
        if (hold[k]) cmp_entry({nm, ".hold"}, ob, hsnap[k]);
        hold[k] = 1'b0;
        if (flush) begin
            q[k].delete();
        end else begin
            if (vld && out_ready && q[k].size() > 0) begin
                cmp_entry({nm, ".out"}, ob, q[k][0]);
                void'(q[k].pop_front());
            end
            if (vld && !out_ready) begin
                hold[k]  = 1'b1;
                hsnap[k] = ob;
            end
            if (in_valid && rdy) q[k].push_back(model(in_instr, pc64, xl));
        end
    endtask

    function automatic exp_t obs32();
        exp_t o;
        o.imm = {32'd0, imm32}; o.fmt = fmt32; o.ill = ill32;
        o.pc  = {32'd0, opc32}; o.tgt = {32'd0, tgt32};
        return o;
    endfunction

    function automatic exp_t obs64();
        exp_t o;
        o.imm = imm64; o.fmt = fmt64; o.ill = ill64; o.pc = opc64; o.tgt = tgt64;
        return o;
    endfunction

    task automatic step(input bit iv, input logic [31:0] ins, input logic [63:0] pc,
                        input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        in_instr  = ins;
        pc64      = pc;
        pc32      = pc[31:0];
        out_ready = ordy;
        flush     = fl;
        #1;
        side(0, obs32(), r32, v32);
        side(1, obs64(), r64, v64);
        @(posedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".v32"},   64'(v32),   64'd0);
        chk({tag, ".r32"},   64'(r32),   64'd1);
        chk({tag, ".imm32"}, 64'(imm32), 64'd0);
        chk({tag, ".fmt32"}, 64'(fmt32), 64'd0);
        chk({tag, ".ill32"}, 64'(ill32), 64'd0);
        chk({tag, ".pc32"},  64'(opc32), 64'd0);
        chk({tag, ".tgt32"}, 64'(tgt32), 64'd0);
        chk({tag, ".v64"},   64'(v64),   64'd0);
        chk({tag, ".r64"},   64'(r64),   64'd1);
        chk({tag, ".imm64"}, imm64,      64'd0);
        chk({tag, ".tgt64"}, tgt64,      64'd0);
    endtask

    localparam logic [6:0] OPS [14] = '{7'b0000011, 7'b0001111, 7'b1100111, 7'b0010011,
                                        7'b0011011, 7'b0100011, 7'b1100011, 7'b1101111,
                                        7'b0110111, 7'b0010111, 7'b1110011, 7'b0110011,
                                        7'b0111011, 7'b0000000};

    function automatic logic [31:0] rand_ins();
        logic [31:0] w = $urandom;
        if ($urandom_range(9) != 0) w[6:0] = OPS[$urandom_range(13)];
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; pc32 = '0; pc64 = '0;
        hold[0] = 1'b0; hold[1] = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk); rst_n = 1'b1;

        // directed decode vectors
        step(1, 32'hFFF0_0093, 64'h0, 1, 0); #2;
        chk("addi.v32", 64'(v32), 64'd1);
        chk("addi.imm32", 64'(imm32), 64'hFFFF_FFFF);
        chk("addi.fmt32", 64'(fmt32), 64'd1);
        chk("addi.ill32", 64'(ill32), 64'd0);
        step(1, 32'hFE00_0CE3, 64'h100, 1, 0); #2;
        chk("beq.imm32", 64'(imm32), 64'hFFFF_FFF4);
        chk("beq.fmt32", 64'(fmt32), 64'd3);
        chk("beq.tgt32", 64'(tgt32), 64'hF4);
        chk("beq.tgt64", tgt64, 64'hF4);
        step(1, 32'hFFC1_2283, 64'h40, 1, 0); #2;
        chk("lw.imm32", 64'(imm32), 64'hFFFF_FFFC);
        chk("lw.fmt32", 64'(fmt32), 64'd1);
        step(1, 32'h8000_02B7, 64'h0, 1, 0); #2;
        chk("lui.imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui.fmt64", 64'(fmt64), 64'd4);
        chk("lui.imm32", 64'(imm32), 64'h8000_0000);
        step(1, 32'h0210_9093, 64'h0, 1, 0); #2;
        chk("slli.imm64", imm64, 64'd33);
        chk("slli.fmt64", 64'(fmt64), 64'd6);
        chk("slli.fmt32", 64'(fmt32), 64'd0);
        chk("slli.imm32", 64'(imm32), 64'd0);
        chk("slli.ill32", 64'(ill32), 64'd1);
        step(1, 32'h0000_0000, 64'h0, 1, 0); #2;
        chk("zero.ill32", 64'(ill32), 64'd1);
        chk("zero.ill64", 64'(ill64), 64'd1);
        step(0, 32'h0, 64'h0, 1, 0);

        // back-pressure: A,B,C with out_ready low for two cycles
        step(1, 32'h0010_0093, 64'h200, 0, 0);
        step(1, 32'h0020_0113, 64'h204, 0, 0); #2;
        chk("bp.r32_low", 64'(r32), 64'd0);
        step(1, 32'h0030_0193, 64'h208, 0, 0);
        step(1, 32'h0030_0193, 64'h208, 1, 0);
        step(1, 32'h0030_0193, 64'h208, 1, 0);
        repeat (3) step(0, 32'h0, 64'h0, 1, 0);

        // flush with O and S full and an input offered
        step(1, 32'h0040_0213, 64'h300, 0, 0);
        step(1, 32'h0050_0293, 64'h304, 0, 0);
        step(1, 32'h0060_0313, 64'h308, 0, 1);
        step(0, 32'h0, 64'h0, 1, 0);
        // flush with only O full: the accepted-looking input is dropped
        step(1, 32'h0070_0393, 64'h30C, 0, 0);
        step(1, 32'h0080_0413, 64'h310, 1, 1);
        step(0, 32'h0, 64'h0, 1, 0);

        // asynchronous reset mid-stall
        step(1, 32'h0090_0493, 64'h400, 0, 0);
        step(1, 32'h00A0_0513, 64'h404, 0, 0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        q[0].delete(); q[1].delete();
        hold[0] = 1'b0; hold[1] = 1'b0;
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 400; n++)
            step($urandom_range(3) != 0, rand_ins(), {$urandom, $urandom},
                 $urandom_range(2) != 0, $urandom_range(39) == 0);
        repeat (4) step(0, 32'h0, 64'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
